// File: rtl/shift_add_mult8_if.sv
// Handshake bundle for the shift-and-add multiplier: request/operands in, status/product out.
interface shift_add_mult8_if #(parameter int WIDTH = 8);
  logic               START;
  logic [WIDTH-1:0]   MCAND;
  logic [WIDTH-1:0]   MPLIER;
  logic               BUSY;
  logic               DONE;
  logic [2*WIDTH-1:0] PRODUCT;

  modport master (output START, MCAND, MPLIER, input BUSY, DONE, PRODUCT);
  modport slave  (input START, MCAND, MPLIER, output BUSY, DONE, PRODUCT);
endinterface

// File: rtl/shift_add_mult8.sv
// Sequential unsigned WIDTHxWIDTH shift-and-add multiplier driving an external WIDTH-bit adder.
// One add-and-shift step per RUN cycle; product registered on the last step.
module shift_add_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  shift_add_mult8_if.slave bus,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  output logic             ADD_CIN,
  input  logic [WIDTH-1:0] ADD_SUM,
  input  logic             ADD_CARRY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH-1:0]     p_hi_q, p_hi_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [2*WIDTH-1:0]   shifted;

  // Adder carry becomes the new MSB, so no product bit is ever dropped.
  assign shifted = {ADD_CARRY, ADD_SUM, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_hi_d    = p_hi_q;
    q_d       = q_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = done_q;
    product_d = product_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (bus.START) begin
          state_d = RUN;
          busy_d  = 1'b1;
          m_d     = bus.MCAND;
          q_d     = bus.MPLIER;
          p_hi_d  = '0;
          count_d = '0;
        end
      end
      RUN: begin
        {p_hi_d, q_d} = shifted;
        count_d       = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d   = FIN;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = shifted;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_hi_q    <= '0;
      q_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_hi_q    <= p_hi_d;
      q_q       <= q_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  // Adder inputs come straight from registers so they are defined in every state.
  assign ADD_A   = p_hi_q;
  assign ADD_B   = q_q[0] ? m_q : '0;
  assign ADD_CIN = 1'b0;

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.PRODUCT = product_q;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Randomized self-checking bench for shift_add_mult8 with a behavioural adder and product model.
module tb_shift_add_mult8;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_carry;
  logic [W:0]   add_res;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_prod;

  shift_add_mult8_if #(.WIDTH(W)) bus ();

  shift_add_mult8 #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .bus      (bus),
    .ADD_A    (add_a),
    .ADD_B    (add_b),
    .ADD_CIN  (add_cin),
    .ADD_SUM  (add_sum),
    .ADD_CARRY(add_carry)
  );

  // Stand-in for the external 8-bit adder.
  assign add_res   = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum   = add_res[W-1:0];
  assign add_carry = add_res[W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int glitch_k, input bit keep_start,
                        output bit carry_seen, output bit b_nonzero);
    carry_seen = 1'b0;
    b_nonzero  = 1'b0;
    bus.START  = 1'b1;
    bus.MCAND  = a;
    bus.MPLIER = b;
    @(negedge clk);
    if (!keep_start) bus.START = 1'b0;
    for (int k = 1; k <= W; k++) begin
      bus.MCAND  = W'($urandom);
      bus.MPLIER = W'($urandom);
      check_val({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
      check_val({tag, "_done_run"}, 32'(bus.DONE), 32'd0);
      check_val({tag, "_prod_hold"}, 32'(bus.PRODUCT), 32'(exp_prod));
      check_val({tag, "_cin"}, 32'(add_cin), 32'd0);
      if (add_carry) carry_seen = 1'b1;
      if (add_b != '0) b_nonzero = 1'b1;
      if (!keep_start) begin
        if (k == glitch_k) begin
          bus.START  = 1'b1;
          bus.MCAND  = 8'd64;
          bus.MPLIER = 8'd6;
        end else begin
          bus.START = 1'b0;
        end
      end
      @(negedge clk);
    end
    exp_prod = 16'(a) * 16'(b);
    check_val({tag, "_done"}, 32'(bus.DONE), 32'd1);
    check_val({tag, "_busy_fin"}, 32'(bus.BUSY), 32'd0);
    check_val({tag, "_product"}, 32'(bus.PRODUCT), 32'(exp_prod));
  endtask

  task automatic idle_after(input string tag);
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val({tag, "_done_idle"}, 32'(bus.DONE), 32'd0);
      check_val({tag, "_busy_idle"}, 32'(bus.BUSY), 32'd0);
      check_val({tag, "_prod_idle"}, 32'(bus.PRODUCT), 32'(exp_prod));
    end
  endtask

  initial begin
    bit cs, bn;
    logic [W-1:0] ra, rb;
    rst_n      = 1'b0;
    bus.START  = 1'b0;
    bus.MCAND  = '0;
    bus.MPLIER = '0;
    exp_prod   = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(bus.BUSY), 32'd0);
    check_val("rst_done", 32'(bus.DONE), 32'd0);
    check_val("rst_prod", 32'(bus.PRODUCT), 32'd0);
    check_val("rst_add_a", 32'(add_a), 32'd0);
    check_val("rst_add_b", 32'(add_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 8'd10, 8'd5, -1, 1'b0, cs, bn);
    check_val("t1_val", 32'(bus.PRODUCT), 32'h0032);
    idle_after("t1");

    run_op("t2", 8'd255, 8'd255, -1, 1'b0, cs, bn);
    check_val("t2_val", 32'(bus.PRODUCT), 32'hFE01);
    check_val("t2_carry_seen", 32'(cs), 32'd1);
    idle_after("t2");

    run_op("t3a", 8'd104, 8'd0, -1, 1'b0, cs, bn);
    check_val("t3a_addb_nz", 32'(bn), 32'd0);
    idle_after("t3a");
    run_op("t3b", 8'd0, 8'd64, -1, 1'b0, cs, bn);
    check_val("t3b_val", 32'(bus.PRODUCT), 32'h0000);
    idle_after("t3b");

    run_op("t4", 8'd2, 8'd5, 3, 1'b0, cs, bn);
    check_val("t4_val", 32'(bus.PRODUCT), 32'h000A);
    idle_after("t4");

    // Reset mid-run: abort at RUN cycle 4.
    exp_prod   = 16'h000A;
    bus.START  = 1'b1;
    bus.MCAND  = 8'd255;
    bus.MPLIER = 8'd0;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    check_val("t5_busy_pre", 32'(bus.BUSY), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_prod = '0;
    check_val("t5_busy_rst", 32'(bus.BUSY), 32'd0);
    check_val("t5_done_rst", 32'(bus.DONE), 32'd0);
    check_val("t5_prod_rst", 32'(bus.PRODUCT), 32'd0);
    check_val("t5_add_a_rst", 32'(add_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_after("t5_abort");
    run_op("t5", 8'd104, 8'd10, -1, 1'b0, cs, bn);
    check_val("t5_val", 32'(bus.PRODUCT), 32'h0410);
    idle_after("t5");

    // START held high: back-to-back ops, DONE every W+1 cycles.
    run_op("t6a", 8'd10, 8'd5, -1, 1'b1, cs, bn);
    check_val("t6a_val", 32'(bus.PRODUCT), 32'h0032);
    run_op("t6b", 8'd2, 8'd5, -1, 1'b1, cs, bn);
    check_val("t6b_val", 32'(bus.PRODUCT), 32'h000A);
    bus.START = 1'b0;
    @(negedge clk);
    check_val("t6_done_end", 32'(bus.DONE), 32'd0);
    idle_after("t6");

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) ra = 8'd255;
      if (i == 1) rb = 8'd255;
      if (i == 2) ra = 8'd1;
      run_op("rnd", ra, rb, ((i % 3) == 0) ? int'($urandom_range(1, W - 1)) : -1,
             1'b0, cs, bn);
      if ((i % 2) == 0) idle_after("rnd");
    end
    idle_after("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
